// File: rtl/tone_arbiter_seq.sv
// Buzzer tone arbiter: shares one tone generator among alarm, key-beep and melody
// requesters with fixed priority, preemption, beat-timed notes and a silent inter-note gap.
module tone_arbiter_seq #(
  parameter int unsigned TICK_DIV  = 10000000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] note0,
  input  logic [7:0] note1,
  input  logic [7:0] note2,
  input  logic [3:0] dur0,
  input  logic [3:0] dur1,
  input  logic [3:0] dur2,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic [2:0] abort,
  output logic [7:0] note_code,
  output logic       tone_en,
  output logic       busy
);

  localparam int unsigned TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned REM_W  = 4;
  localparam int unsigned NREQ   = 3;
  localparam int unsigned NOTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [1:0]          owner_q, owner_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [NREQ-1:0]     abort_q, abort_d;
  logic [NOTE_W-1:0]   note_code_q, note_code_d;
  logic                tone_en_q, tone_en_d;
  logic                busy_q, busy_d;

  logic                tick_end_c;
  logic [1:0]          win_c;
  logic [NOTE_W-1:0]   win_note_c;
  logic [REM_W-1:0]    win_dur_c;
  logic [NREQ-1:0]     owner_oh_c;
  logic [NREQ-1:0]     higher_c;
  logic                start_c;
  logic                finish_c;

  // Fixed-priority winner (lowest set index) and its note/duration.
  always_comb begin
    win_c = 2'd2;
    if (req[1]) win_c = 2'd1;
    if (req[0]) win_c = 2'd0;
    case (win_c)
      2'd0:    begin win_note_c = note0; win_dur_c = dur0; end
      2'd1:    begin win_note_c = note1; win_dur_c = dur1; end
      default: begin win_note_c = note2; win_dur_c = dur2; end
    endcase
    owner_oh_c = NREQ'(1) << owner_q;
    higher_c   = req & (owner_oh_c - NREQ'(1));
    tick_end_c = (tcnt_q == TCNT_W'(TICK_DIV - 1));
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tick_end_c ? '0 : tcnt_q + TCNT_W'(1);
    rem_d    = rem_q;
    owner_d  = owner_q;
    done_d   = '0;
    abort_d  = '0;
    start_c  = 1'b0;
    finish_c = 1'b0;

    case (state_q)
      // A pulse still on the outputs is the requester's drop cycle, so req is not sampled then.
      S_IDLE: begin
        if (req != '0 && (done_q | abort_q) == '0) start_c = 1'b1;
      end
      S_PLAY: begin
        if (higher_c != '0) begin
          abort_d = owner_oh_c;
          start_c = 1'b1;
        end else if ((req & owner_oh_c) == '0) begin
          abort_d  = owner_oh_c;
          finish_c = 1'b1;
        end else if (tick_end_c) begin
          if (rem_q == REM_W'(1)) begin
            done_d   = owner_oh_c;
            finish_c = 1'b1;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick_end_c) begin
          if (rem_q <= REM_W'(1)) begin
            state_d = S_IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_c) begin
      state_d = S_PLAY;
      owner_d = win_c;
      rem_d   = (win_dur_c == '0) ? REM_W'(1) : win_dur_c;
      tcnt_d  = '0;
    end
    if (finish_c) begin
      if (GAP_TICKS == 0) begin
        state_d = S_IDLE;
        rem_d   = '0;
      end else begin
        state_d = S_GAP;
        rem_d   = REM_W'(GAP_TICKS);
        tcnt_d  = '0;
      end
    end

    gnt_d       = (state_d == S_PLAY) ? (NREQ'(1) << owner_d) : '0;
    note_code_d = start_c ? win_note_c : ((state_d == S_PLAY) ? note_code_q : '0);
    tone_en_d   = (state_d == S_PLAY);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      rem_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      abort_q     <= '0;
      note_code_q <= '0;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      rem_q       <= rem_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      note_code_q <= note_code_d;
      tone_en_q   <= tone_en_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign note_code = note_code_q;
  assign tone_en   = tone_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tone_arbiter_seq.sv
// Bench for tone_arbiter_seq: two instances (gap of one tick and no gap) driven with the same
// inputs, checked against a cycles-remaining reference model plus directed tables and sequences.
module tb_tone_arbiter_seq;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [7:0] note0, note1, note2;
  logic [3:0] dur0, dur1, dur2;
  logic [2:0] gnt1, done1, abort1, gnt0, done0, abort0;
  logic [7:0] nc1, nc0;
  logic       te1, bz1, te0, bz0;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  tone_arbiter_seq #(.TICK_DIV(TD), .GAP_TICKS(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .note0(note0), .note1(note1), .note2(note2),
    .dur0(dur0), .dur1(dur1), .dur2(dur2),
    .gnt(gnt1), .done(done1), .abort(abort1),
    .note_code(nc1), .tone_en(te1), .busy(bz1)
  );

  tone_arbiter_seq #(.TICK_DIV(TD), .GAP_TICKS(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .note0(note0), .note1(note1), .note2(note2),
    .dur0(dur0), .dur1(dur1), .dur2(dur2),
    .gnt(gnt0), .done(done0), .abort(abort0),
    .note_code(nc0), .tone_en(te0), .busy(bz0)
  );

  // Reference model: mode 0 idle, 1 play, 2 gap; 'left' is cycles remaining in the phase.
  typedef struct {
    int         mode;
    int         owner;
    int         left;
    logic [7:0] note;
    logic       pv;
    logic [2:0] gnt, done, abort;
    logic [7:0] nc;
    logic       te, busy;
  } model_t;

  model_t m1, m0;

  function automatic model_t mreset();
    model_t s;
    s.mode = 0; s.owner = 0; s.left = 0; s.note = '0; s.pv = 1'b0;
    s.gnt = '0; s.done = '0; s.abort = '0; s.nc = '0; s.te = 1'b0; s.busy = 1'b0;
    return s;
  endfunction

  function automatic model_t mstep(input model_t m, input int g, input logic [2:0] r);
    model_t     s = m;
    logic [7:0] nn [3];
    int         dd [3];
    int         k;
    bit         start = 0, fin = 0;
    nn = '{note0, note1, note2};
    dd = '{int'(dur0), int'(dur1), int'(dur2)};
    k  = r[0] ? 0 : (r[1] ? 1 : 2);
    s.done = '0; s.abort = '0;
    case (m.mode)
      0: if (r != 0 && !m.pv) start = 1;
      1: begin
        if (r != 0 && k < m.owner) begin
          s.abort = 3'(1 << m.owner); start = 1;
        end else if (!r[m.owner]) begin
          s.abort = 3'(1 << m.owner); fin = 1;
        end else begin
          s.left--;
          if (s.left == 0) begin s.done = 3'(1 << m.owner); fin = 1; end
        end
      end
      default: begin
        s.left--;
        if (s.left == 0) s.mode = 0;
      end
    endcase
    if (start) begin
      s.mode = 1; s.owner = k; s.note = nn[k];
      s.left = ((dd[k] == 0) ? 1 : dd[k]) * TD;
    end
    if (fin) begin
      if (g == 0) s.mode = 0;
      else begin s.mode = 2; s.left = g * TD; end
    end
    s.pv   = (s.done | s.abort) != 0;
    s.gnt  = (s.mode == 1) ? 3'(1 << s.owner) : 3'b000;
    s.nc   = (s.mode == 1) ? s.note : 8'h00;
    s.te   = (s.mode == 1);
    s.busy = (s.mode != 0);
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input logic [2:0] g, input logic [2:0] d,
                         input logic [2:0] a, input logic [7:0] nc, input logic te,
                         input logic bz, input model_t m);
    chk({tag, ".gnt"},   int'(g),  int'(m.gnt));
    chk({tag, ".done"},  int'(d),  int'(m.done));
    chk({tag, ".abort"}, int'(a),  int'(m.abort));
    chk({tag, ".note"},  int'(nc), int'(m.nc));
    chk({tag, ".ten"},   int'(te), int'(m.te));
    chk({tag, ".busy"},  int'(bz), int'(m.busy));
  endtask

  // One clock: step both models with the current inputs, then compare after the edge.
  task automatic tick();
    m1 = mstep(m1, 1, req);
    m0 = mstep(m0, 0, req);
    @(posedge clk);
    #1;
    cmp_dut("g1", gnt1, done1, abort1, nc1, te1, bz1, m1);
    cmp_dut("g0", gnt0, done0, abort0, nc0, te0, bz0, m0);
  endtask

  task automatic drain();
    req = '0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       te;
    logic       busy;
    logic [7:0] nc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int  cnt, lows;
    bit  found, seen_hi, in_low, meas;

    // Single-note expectations for the one-tick-gap instance: 12 PLAY, done, 4 GAP, IDLE.
    for (int i = 0; i < 12; i++) tbl[i] = '{3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 8'h08};
    tbl[12] = '{3'b001, 3'b000, 3'b001, 1'b0, 1'b1, 8'h00};
    for (int i = 13; i < 16; i++) tbl[i] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 8'h00};
    for (int i = 16; i < 18; i++) tbl[i] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00};

    rst_n = 1'b0;
    req = '0;
    note0 = 8'h08; note1 = 8'h2A; note2 = 8'h53;
    dur0 = 4'd3; dur1 = 4'd1; dur2 = 4'd2;
    m1 = mreset();
    m0 = mreset();
    #12;
    chk("rst.gnt",  int'(gnt1), 0);
    chk("rst.ten",  int'(te1),  0);
    chk("rst.note", int'(nc1),  0);
    chk("rst.busy", int'(bz1),  0);
    chk("rst.pulse", int'(done1 | abort1 | done0 | abort0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single note via table
    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req;
      tick();
      chk("tbl.gnt",  int'(gnt1),  int'(tbl[i].gnt));
      chk("tbl.done", int'(done1), int'(tbl[i].done));
      chk("tbl.ten",  int'(te1),   int'(tbl[i].te));
      chk("tbl.busy", int'(bz1),   int'(tbl[i].busy));
      chk("tbl.note", int'(nc1),   int'(tbl[i].nc));
    end

    // Simultaneous requests 1 and 2
    req = 3'b110;
    tick();
    chk("sim.first_gnt", int'(gnt1), 3'b010);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      req &= ~(m1.done | m1.abort);
      tick();
      if (gnt1 == 3'b100) found = 1;
    end
    chk("sim.second_gnt", int'(found), 1);
    chk("sim.note2", int'(nc1), 8'h53);
    drain();

    // Preemption of requester 2 by requester 0 in its 6th PLAY cycle
    note0 = 8'h41; dur0 = 4'd2; note2 = 8'h67; dur2 = 4'd5;
    req = 3'b100;
    repeat (6) tick();
    req = 3'b101;
    tick();
    chk("pre.abort", int'(abort1), 3'b100);
    chk("pre.gnt",   int'(gnt1),   3'b001);
    chk("pre.note",  int'(nc1),    8'h41);
    chk("pre.ten",   int'(te1),    1);
    req = 3'b001;
    cnt = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt1 == 3'b001 && te1) cnt++;
      else break;
    end
    chk("pre.len",  cnt, 2 * TD);
    chk("pre.done", int'(done1), 3'b001);
    drain();

    // Zero duration plays one tick
    note1 = 8'h19; dur1 = 4'd0;
    req = 3'b010;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (te1) cnt++;
      if (done1 != 0 || abort1 != 0 || (!te1 && cnt > 0)) break;
    end
    chk("zd.len",  cnt, TD);
    chk("zd.done", int'(done1), 3'b010);
    drain();

    // Owner drop mid-note
    dur1 = 4'd5;
    req = 3'b010;
    repeat (3) tick();
    req = 3'b000;
    tick();
    chk("drop.abort", int'(abort1), 3'b010);
    chk("drop.done",  int'(done1),  0);
    chk("drop.gnt",   int'(gnt1),   0);
    chk("drop.busy",  int'(bz1),    1);
    drain();

    // Back-to-back on the no-gap instance with req held
    dur0 = 4'd1;
    req = 3'b001;
    lows = 0; seen_hi = 0; in_low = 0; meas = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (te0) begin
        if (in_low) meas = 1;
        seen_hi = 1;
      end else if (seen_hi && !meas) begin
        in_low = 1;
        lows++;
      end
    end
    chk("b2b.regrant", int'(meas), 1);
    chk("b2b.lows", lows, 2);
    drain();

    // Asynchronous reset in the middle of a note
    dur0 = 4'd4;
    req = 3'b001;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    m1 = mreset();
    m0 = mreset();
    #1;
    chk("arst.gnt1",  int'(gnt1), 0);
    chk("arst.ten1",  int'(te1),  0);
    chk("arst.note1", int'(nc1),  0);
    chk("arst.gnt0",  int'(gnt0), 0);
    chk("arst.ten0",  int'(te0),  0);
    chk("arst.busy1", int'(bz1),  0);
    req = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) tick();
    chk("arst.idle",  int'(bz1 | bz0), 0);
    chk("arst.nopulse", int'(done1 | abort1 | done0 | abort0), 0);

    // Randomized requesters that honour the drop-on-pulse rule
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (m1.done[b] || m1.abort[b]) req[b] = 1'b0;
        else if (!req[b] && $urandom_range(0, 7) == 0) req[b] = 1'b1;
        else if (req[b] && $urandom_range(0, 40) == 0) req[b] = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        note0 = 8'($urandom); note1 = 8'($urandom); note2 = 8'($urandom);
        dur0 = 4'($urandom_range(0, 3));
        dur1 = 4'($urandom_range(0, 3));
        dur2 = 4'($urandom_range(0, 3));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/tone_arbiter_seq.md
Name: tone_arbiter_seq

Overview:
- Shares the single buzzer tone generator between three requesters: alarm, key-beep and melody player.
- Uses fixed priority with preemption.
- Times each granted note in beat ticks and inserts a silent gap between notes.
- Drives the 8-bit note code {hight,mid,low} and tone enable that feed the tone generator's divider-preload lookup.

Parameters:
- TICK_DIV, 10000000: clocks per beat tick. Simulation uses 4.
- GAP_TICKS, 1: silent ticks after each note. 0 means return directly to IDLE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  3  level request per requester; bit 0 is highest priority
- note0  in  8  note code of requester 0 ({hight[1:0],mid[2:0],low[2:0]})
- note1  in  8  note code of requester 1
- note2  in  8  note code of requester 2
- dur0  in  4  duration of requester 0 in ticks; 0 is treated as 1
- dur1  in  4  duration of requester 1 in ticks
- dur2  in  4  duration of requester 2 in ticks
- gnt  out  3  one-hot grant, high for the whole PLAY phase
- done  out  3  one-cycle pulse: note completed normally
- abort  out  3  one-cycle pulse: note cut short by preemption or req drop
- note_code  out  8  note code to the tone generator; 0 when silent
- tone_en  out  1  tone generator enable
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; gnt, done, abort, note_code, tone_en, busy = 0.
  - Tick counter tcnt=0, remaining count rem=0, latched owner and note cleared.
- tcnt:
  - Counts 0..TICK_DIV-1 and wraps.
  - Cleared to 0 on every entry to PLAY or GAP, so the first tick of a note is full length.
  - tick_end = (tcnt==TICK_DIV-1).
- IDLE:
  - If req!=0, select the lowest set index k.
  - Latch note_k, rem = max(dur_k,1), owner = k.
  - Next cycle: state=PLAY, gnt=onehot(k), note_code=note_k, tone_en=1.
  - Grant latency: 1 cycle from the first sampled req.
- PLAY, checked in this priority order:
  1. Preemption: if req has a set bit with index < owner, the owner gets an abort pulse next cycle. Next cycle enters PLAY for the new winner, fresh latch, no gap. gnt switches directly; tone_en stays high.
  2. Owner drop: if req[owner]==0, abort pulse next cycle, enter GAP (or IDLE if GAP_TICKS=0).
  3. Tick end: on tick_end, rem decrements. If rem==1 at tick_end, done[owner] pulses next cycle and state goes to GAP (or IDLE).
- tone_en length: an uninterrupted note holds tone_en high for exactly rem_initial*TICK_DIV cycles.
- GAP:
  - gnt=0, tone_en=0, note_code=0.
  - Lasts GAP_TICKS*TICK_DIV cycles, then IDLE.
  - Requests arriving during GAP are held off until IDLE; no preemption in GAP.
- Requester obligations:
  - req must drop in the cycle done or abort is seen.
  - req still high when IDLE is reached is a new request and is re-granted.
- Pulse rules: done and abort are mutually exclusive per cycle, one-hot, and registered.
- note/dur change during PLAY: ignored; values are latched at grant.
- Reset mid-note: all outputs immediately 0; no done or abort pulse is generated.
- Widths: rem is 4 bits; tcnt is sized ceil(log2(TICK_DIV)).

Test Plan:
- Single note (TICK_DIV=4, GAP_TICKS=1): req=001, note0=8'h08, dur0=3.
  - gnt=001 and tone_en rise 1 cycle later; tone_en high 12 cycles.
  - done=001 pulses 1 cycle; 4 silent GAP cycles; busy falls.
- Simultaneous requests: req=110 in the same cycle.
  - gnt=010 first. After its done plus the gap, gnt=100 with note2 on note_code.
- Preemption: requester 2 playing dur2=5; req[0] asserts at its 6th PLAY cycle.
  - Next cycle: abort=100, gnt=001, note_code=note0, tone_en stays high (no gap).
  - Requester 0 note lasts a full dur0*4 cycles.
- Zero duration and owner drop:
  - dur1=0 → tone_en high exactly 4 cycles.
  - Separately, drop req[1] mid-note → abort=010, GAP entered, no done.
- GAP_TICKS=0 back-to-back: req held 001 after done.
  - IDLE 1 cycle, then re-grant; tone_en low for exactly 2 cycles between notes.
- Async reset mid-PLAY: rst_n low between clock edges.
  - gnt, tone_en, note_code go to 0 immediately.
  - After release with req=000: stays IDLE, no pulses.
